pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-field stage latches between pipeline stages.
- Carries a generic payload split into a control field (bubble-sensitive: write enables, result-select) and a data field (ALU result, load data, PC values, immediates).
- Adds valid/ready flow control with a 2-entry skid buffer, plus flush. Stalls propagate without combinational ready paths.
- Sits between any two stages (EX/MEM, MEM/WB, ...) of the pipelined core.

Parameters:
- CTRL_W, 8: width of the control field. Forced to zero whenever the stage outputs a bubble.
- DATA_W, 256: width of the data field. Holds its value on bubbles; never zeroed except at reset.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  kill all held entries (branch mispredict / trap).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; driven only from flops.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  control field; zero when out_valid=0.
- out_data  output  DATA_W  data field.

Behaviour:
- Storage: main entry (main_v, main_ctrl, main_data) and skid entry (skid_v, skid_ctrl, skid_data).
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs: out_valid = main_v; out_ctrl = main_v ? main_ctrl : 0; out_data = main_data; in_ready = ~skid_v & ~reset.
- States: EMPTY (main_v=0, skid_v=0), BUSY (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). main_v=0 with skid_v=1 is illegal and must never occur.
- EMPTY: in_fire -> BUSY, main<=in. Otherwise stay.
- BUSY:
  - in_fire & out_fire -> BUSY, main<=in.
  - in_fire & ~out_fire -> FULL, skid<=in.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL: in_ready=0, so no accept. out_fire -> BUSY, main<=skid, skid_v<=0. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1 per cycle with out_ready held high.
- Ordering: strictly FIFO. No payload is dropped or duplicated except by flush/reset.
- Flush: highest priority below reset. Next edge: main_v=0, skid_v=0, main_ctrl=0, skid_ctrl=0.
  - A concurrent in_fire is discarded.
  - A concurrent out_fire counts as consumed downstream (the output is still visible that cycle).
  - Data fields hold their values.
- Reset: next edge sets every flop to zero, so out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=0 while reset is high; 1 on the first cycle after reset deasserts.
  - Reset mid-transfer discards all entries.
- Flush and reset together: reset wins (identical except the data fields clear).
- out_ready may toggle freely; in_valid may drop without acceptance (no stickiness required of upstream).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Extra output ports stall_cnt (32 bits) and bubble_cnt (32 bits).
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - bubble_cnt increments on each cycle with ~out_valid & ~flush.
  - Both saturate at 32'hFFFF_FFFF, clear on reset, and are unaffected by flush.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then stream: in_valid=1 for 4 cycles with ctrl=1..4, data=0xA0..0xA3, out_ready=1 -> out_valid high from cycle+1, outputs 1..4 in order, in_ready constant 1.
- Backpressure: stream 3 items, out_ready=0 from 2nd cycle -> FULL after 2 accepts, in_ready=0, item 3 held upstream. Then out_ready=1 -> order 1,2,3 with no loss.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flushed/offered items never appear on the output.
- Bubble control: accept ctrl=0xFF, data=0x55, then drain with no new input -> out_valid=0, out_ctrl=0x00, out_data remains 0x55.
- Reset asserted mid-stream in FULL -> next cycle all outputs 0, in_ready=0 while reset is high, 1 the cycle after release.
- PIPE_STAGE_PERF_EN: hold out_ready=0 with main valid for 5 cycles -> stall_cnt=5. Idle for 3 cycles after reset -> bubble_cnt=3. A flush cycle does not increment bubble_cnt.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// BUSY  | main entry valid, skid empty
// FULL  | main and skid valid, in_ready=0
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Encoding chosen so bit 1 is main_v and bit 0 is skid_v.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    logic              main_v;
    logic              skid_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    assign main_v    = state[1];
    assign skid_v    = state[0];
    assign in_ready  = ~skid_v & ~reset;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Data fields deliberately hold; only control is scrubbed.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= BUSY;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        state     <= FULL;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state     <= BUSY;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && !flush && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based model.
// Define PIPE_STAGE_PERF_EN to also check the performance counters.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_ctrl;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_ctrl;
    logic [255:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;
`endif

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   c;
        logic [255:0] d;
    } ent_t;

    ent_t         q[$];
    logic [255:0] m_data;
    longint       m_stall;
    longint       m_bubble;
    int           errors;
    int           checks;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; model advances at the rising edge, outputs checked on the falling edge.
    task automatic step(input logic iv, input logic [7:0] c, input logic [255:0] d,
                        input logic ordy, input logic fl, input logic rst);
        bit   in_f;
        bit   out_f;
        ent_t e;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        chk("in_ready", in_ready, (q.size() < 2 && !rst));
        @(posedge clk);
        in_f = iv && q.size() < 2 && !rst;
        out_f = q.size() > 0 && ordy;
        if (rst) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (q.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (q.size() == 0 && !fl && m_bubble < 64'hFFFF_FFFF) m_bubble++;
        end
        if (rst) begin
            q.delete();
            m_data = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_data = q[0].d;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : 8'h00);
        chk("out_data", out_data, m_data);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall[31:0]);
        chk("bubble_cnt", bubble_cnt, m_bubble[31:0]);
`endif
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        errors   = 0;
        checks   = 0;
        m_data   = '0;
        m_stall  = 0;
        m_bubble = 0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("reset_data", out_data, 256'h0);

        // Streaming at full throughput
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 256'(8'hA0 + i - 1), 1, 0, 0);
        chk("stream_last", out_ctrl, 256'h4);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Backpressure into FULL, then drain in order
        step(1, 8'h01, 256'h11, 1, 0, 0);
        step(1, 8'h02, 256'h12, 0, 0, 0);
        step(1, 8'h03, 256'h13, 0, 0, 0);
        chk("bp_full_ready", in_ready, 256'h0);
        step(1, 8'h03, 256'h13, 1, 0, 0);
        step(1, 8'h03, 256'h13, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

        // Flush while FULL with a new item on offer
        step(1, 8'h05, 256'h15, 0, 0, 0);
        step(1, 8'h06, 256'h16, 0, 0, 0);
        step(1, 8'h07, 256'h17, 0, 1, 0);
        chk("flush_valid", out_valid, 256'h0);
        chk("flush_ctrl", out_ctrl, 256'h0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Bubble keeps data, zeroes control
        step(1, 8'hFF, 256'h55, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("bubble_ctrl", out_ctrl, 256'h0);
        chk("bubble_data", out_data, 256'h55);
        step(0, 0, 0, 1, 0, 0);

        // Reset in FULL
        step(1, 8'h21, 256'h31, 0, 0, 0);
        step(1, 8'h22, 256'h32, 0, 0, 0);
        step(1, 8'h23, 256'h33, 0, 0, 1);
        chk("rst_mid_data", out_data, 256'h0);
        step(1, 8'h24, 256'h34, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

`ifdef PIPE_STAGE_PERF_EN
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("perf_bubble3", bubble_cnt, 256'd3);
        step(1, 8'h01, 256'h1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        chk("perf_stall5", stall_cnt, 256'd5);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("perf_flush_bubble", bubble_cnt, 256'd4);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), rnd256(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
